lavatory_scheduler: RTL

Sequential allocator for the aircraft's three lavatories: lavatory 0 is women-only, lavatories 1 and 2 are unisex. The block keeps waiting counts per gender and reserves free lavatories for waiting passengers, alternating fairly between women and men on the unisex lavatories. It tracks each lavatory through reservation, occupancy and an optional cleaning phase. It replaces the purely combinational "lavatory free" indicators and sits between the panel switches/door sensors and the LED outputs.

---
 rtl/lav_pkg.sv | 24 ++
 rtl/lav_slot.sv | 97 +++++++++
 rtl/lavatory_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lav_pkg.sv
// Shared types and constants for the lavatory scheduler.
//
// Contents:
//   lav_state_t - 2-bit per-lavatory state (FREE, RESERVED, OCCUPIED, CLEANING)
//   LAV_F_ONLY  - index of the women-only lavatory
//   LAV_UNI0/1  - indices of the two unisex lavatories, in grant-priority order
//   NLAV        - number of lavatories
//
// The CLEANING encoding is only ever produced when LAV_CLEANING_EN is defined.
package lav_pkg;

   typedef enum logic [1:0] {
      LAV_FREE     = 2'b00,
      LAV_RESERVED = 2'b01,
      LAV_OCCUPIED = 2'b10,
      LAV_CLEANING = 2'b11
   } lav_state_t;

   localparam int LAV_F_ONLY = 0;
   localparam int LAV_UNI0   = 1;
   localparam int LAV_UNI1   = 2;
   localparam int NLAV       = 3;

endpackage

// File: rtl/lav_slot.sv
// Per-lavatory state machine with its reservation / cleaning timer.
//
// Ports:
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset
//   grant_i    - a reservation is being issued to this lavatory this cycle
//   occupied_i - door-lock sensor, already synchronous to clk_i
//   state_o    - current registered state
//
// Build option: LAV_CLEANING_EN inserts a CLEANING phase of CLEAN_CYCLES
// cycles between OCCUPIED and FREE; without it OCCUPIED returns straight to FREE.
module lav_slot
   import lav_pkg::*;
#(
   parameter int RESERVE_TIMEOUT = 16,
   parameter int CLEAN_CYCLES    = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       grant_i,
   input  logic       occupied_i,
   output lav_state_t state_o
);

   // One timer serves both the reservation hold and the cleaning phase, so it
   // is sized for the longer of the two.
   localparam int TMAX = (RESERVE_TIMEOUT > CLEAN_CYCLES) ? RESERVE_TIMEOUT : CLEAN_CYCLES;
   localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

   lav_state_t    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= LAV_FREE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // A grant wins over a simultaneous door lock in FREE: the lavatory is
   // RESERVED first and moves to OCCUPIED on the following edge.
   // The reservation expires on the edge where the timer already shows
   // RESERVE_TIMEOUT-1, i.e. RESERVE_TIMEOUT edges after the grant edge.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         LAV_FREE: begin
            if (grant_i) begin
               state_d = LAV_RESERVED;
               timer_d = '0;
            end else if (occupied_i) begin
               state_d = LAV_OCCUPIED;
            end
         end
         LAV_RESERVED: begin
            if (occupied_i) begin
               state_d = LAV_OCCUPIED;
            end else if (timer_q == TW'(RESERVE_TIMEOUT - 1)) begin
               state_d = LAV_FREE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         LAV_OCCUPIED: begin
            if (!occupied_i) begin
`ifdef LAV_CLEANING_EN
               state_d = LAV_CLEANING;
               timer_d = '0;
`else
               state_d = LAV_FREE;
`endif
            end
         end
         LAV_CLEANING: begin
`ifdef LAV_CLEANING_EN
            if (timer_q == TW'(CLEAN_CYCLES - 1)) begin
               state_d = LAV_FREE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
`else
            state_d = LAV_FREE;
`endif
         end
         default: state_d = LAV_FREE;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: rtl/lavatory_scheduler.sv
// Allocator for three aircraft lavatories (0 women-only, 1 and 2 unisex).
// Keeps per-gender waiting counts, reserves free lavatories for waiting
// passengers and alternates women/men fairly on the unisex lavatories.
//
// Ports:
//   clk_2       - clock
//   reset_n     - asynchronous active-low reset
//   req_f/req_m - one-cycle pulse: a woman / man joins the queue
//   occupied    - door-lock sensors, bit i = lavatory i (synchronous)
//   grant_valid - one-cycle pulse: a reservation was issued
//   grant_f     - grant gender (1 = woman), valid with grant_valid
//   grant_lav   - granted lavatory index, valid with grant_valid
//   wait_f/m    - women / men waiting
//   free_f      - any lavatory FREE
//   free_m      - a unisex lavatory FREE
//   lav_state   - 2 bits per lavatory, lavatory i at [2i+1:2i]
//   overflow    - sticky: a request was dropped on a saturated counter
//
// Build option: LAV_CLEANING_EN enables the cleaning phase inside lav_slot.
module lavatory_scheduler
   import lav_pkg::*;
#(
   parameter int NQ              = 4,
   parameter int RESERVE_TIMEOUT = 16,
   parameter int CLEAN_CYCLES    = 8
) (
   input  logic              clk_2,
   input  logic              reset_n,
   input  logic              req_f,
   input  logic              req_m,
   input  logic [NLAV-1:0]   occupied,
   output logic              grant_valid,
   output logic              grant_f,
   output logic [1:0]        grant_lav,
   output logic [NQ-1:0]     wait_f,
   output logic [NQ-1:0]     wait_m,
   output logic              free_f,
   output logic              free_m,
   output logic [2*NLAV-1:0] lav_state,
   output logic              overflow
);

   lav_state_t      slot_state [NLAV];
   logic [NLAV-1:0] lav_free;
   logic [NLAV-1:0] slot_grant;

   logic [NQ-1:0] wait_f_q, wait_f_d;
   logic [NQ-1:0] wait_m_q, wait_m_d;
   logic          rr_f_q, rr_f_d;
   logic          overflow_q, overflow_d;
   logic          grant_valid_q, grant_f_q;
   logic [1:0]    grant_lav_q;

   logic       gnt_any, gnt_f, gnt_uni;
   logic [1:0] gnt_lav;
   logic       f_nz, m_nz, f_gnt, m_gnt;

   for (genvar i = 0; i < NLAV; i++) begin : g_slot
      lav_slot #(
         .RESERVE_TIMEOUT(RESERVE_TIMEOUT),
         .CLEAN_CYCLES   (CLEAN_CYCLES)
      ) u_slot (
         .clk_i     (clk_2),
         .rst_ni    (reset_n),
         .grant_i   (slot_grant[i]),
         .occupied_i(occupied[i]),
         .state_o   (slot_state[i])
      );
      assign lav_free[i]         = (slot_state[i] == LAV_FREE);
      assign slot_grant[i]       = gnt_any && (gnt_lav == 2'(i));
      assign lav_state[2*i +: 2] = slot_state[i];
   end

   // Grant selection looks only at registered queue and slot state. Women get
   // first call on lavatory 0; otherwise the lowest free unisex lavatory goes
   // to whichever queue is non-empty, round-robin when both are.
   always_comb begin
      f_nz    = (wait_f_q != '0);
      m_nz    = (wait_m_q != '0);
      gnt_any = 1'b0;
      gnt_f   = 1'b0;
      gnt_uni = 1'b0;
      gnt_lav = 2'(LAV_F_ONLY);
      if (f_nz && lav_free[LAV_F_ONLY]) begin
         gnt_any = 1'b1;
         gnt_f   = 1'b1;
      end else if (lav_free[LAV_UNI0] || lav_free[LAV_UNI1]) begin
         gnt_lav = lav_free[LAV_UNI0] ? 2'(LAV_UNI0) : 2'(LAV_UNI1);
         gnt_any = f_nz || m_nz;
         gnt_uni = gnt_any;
         gnt_f   = (f_nz && m_nz) ? rr_f_q : f_nz;
      end
   end

   // Queue counters: a request and a grant in the same cycle cancel. A
   // saturated counter drops a lone request and raises the sticky overflow.
   always_comb begin
      f_gnt    = gnt_any && gnt_f;
      m_gnt    = gnt_any && !gnt_f;
      wait_f_d = wait_f_q;
      wait_m_d = wait_m_q;
      if (req_f && !f_gnt && !(&wait_f_q)) wait_f_d = wait_f_q + NQ'(1);
      else if (!req_f && f_gnt)            wait_f_d = wait_f_q - NQ'(1);
      if (req_m && !m_gnt && !(&wait_m_q)) wait_m_d = wait_m_q + NQ'(1);
      else if (!req_m && m_gnt)            wait_m_d = wait_m_q - NQ'(1);
      overflow_d = overflow_q
                 | (req_f && !f_gnt && (&wait_f_q))
                 | (req_m && !m_gnt && (&wait_m_q));
      rr_f_d = gnt_uni ? !rr_f_q : rr_f_q;
   end

   // rr_f_q = 1 means women have the next turn on a contested unisex grant.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         wait_f_q      <= '0;
         wait_m_q      <= '0;
         rr_f_q        <= 1'b1;
         overflow_q    <= 1'b0;
         grant_valid_q <= 1'b0;
         grant_f_q     <= 1'b0;
         grant_lav_q   <= '0;
      end else begin
         wait_f_q      <= wait_f_d;
         wait_m_q      <= wait_m_d;
         rr_f_q        <= rr_f_d;
         overflow_q    <= overflow_d;
         grant_valid_q <= gnt_any;
         grant_f_q     <= gnt_any ? gnt_f : 1'b0;
         grant_lav_q   <= gnt_any ? gnt_lav : 2'd0;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_f     = grant_f_q;
   assign grant_lav   = grant_lav_q;
   assign wait_f      = wait_f_q;
   assign wait_m      = wait_m_q;
   assign overflow    = overflow_q;
   assign free_f      = |lav_free;
   assign free_m      = lav_free[LAV_UNI0] | lav_free[LAV_UNI1];

endmodule
